ren_recovery_ctrl: RTL
======================

REN_RECOVERY_CTRL -- requirements
Module: ren_recovery_ctrl

Interface
REQ-001 SHALL have parameter ARN_BITS, default 6, architectural register number width.
REQ-002 SHALL have parameter PRN_BITS, default 6, physical register number width.
REQ-003 SHALL have parameter MAX_OPERANDS, default 3, rename lanes per cycle.
REQ-004 SHALL have parameter LOG_DEPTH, default 32, undo-log entries, power of two and at least MAX_OPERANDS; PTR_BITS = $clog2(LOG_DEPTH)+1.
REQ-005 Ports: clk  in  1  clock; rising edge.
REQ-006 Ports: rst  in  1  reset; asynchronous, active-high.
REQ-007 Ports: alloc_valid[MAX_OPERANDS]  in  1  renamer wrote a destination mapping on this lane.
REQ-008 Ports: alloc_arn / alloc_old_prn / alloc_new_prn[MAX_OPERANDS]  in  ARN_BITS/PRN_BITS/PRN_BITS  overwritten mapping and new PRN.
REQ-009 Ports: alloc_ready  out  1  log can accept MAX_OPERANDS records and state is IDLE.
REQ-010 Ports: log_tail  out  PTR_BITS  tail pointer before this cycle's pushes; the ROB snapshots it per instruction.
REQ-011 Ports: commit_count  in  $clog2(MAX_OPERANDS+1)  records retired from head this cycle.
REQ-012 Ports: retire_free_valid[MAX_OPERANDS] / retire_free_prn[MAX_OPERANDS]  out  1/PRN_BITS  old PRNs of retired records, returned to the free list.
REQ-013 Ports: flush_valid  in  1; flush_ptr  in  PTR_BITS  log position to roll back to.
REQ-014 Ports: restore_valid / restore_arn / restore_prn  out  1/ARN_BITS/PRN_BITS  rewrite one remap entry to its old PRN, marked ready.
REQ-015 Ports: walk_free_valid / walk_free_prn  out  1/PRN_BITS  squashed new PRN returned to the free list.
REQ-016 Ports: rename_stall  out  1  high in any state except IDLE; flush_done  out  1  one-cycle pulse.

Function
REQ-017 Log SHALL be circular with head/tail pointers PTR_BITS wide, including a wrap bit; full = equal index with differing wrap bits; occupancy = tail - head modulo 2^PTR_BITS.
REQ-018 In IDLE with alloc_ready high, valid lanes SHALL be compacted in lane order into consecutive entries starting at tail; tail advances by the number of valid lanes; lanes with alloc_valid low are never written.
REQ-019 alloc_ready SHALL be low when free entries < MAX_OPERANDS; pushes presented while alloc_ready is low SHALL be dropped.
REQ-020 commit_count=k SHALL pop k records from head in the same cycle, driving retire_free lanes 0..k-1 combinationally from the head entries; commit is honoured in every state.
REQ-021 commit_count greater than occupancy SHALL be clamped to occupancy.
REQ-022 FSM states: IDLE, WALK, DONE.
REQ-023 IDLE + flush_valid: latch target=flush_ptr; go to WALK if tail != target, otherwise go to DONE; pushes in that cycle are dropped.
REQ-024 WALK: each cycle, tail decrements by 1 and the entry at the new tail drives restore_* (arn, old_prn) and walk_free_* (new_prn), both valid; go to DONE in the cycle in which the new tail equals target.
REQ-025 Records are undone youngest-first, so multiple writes to one ARN SHALL leave its oldest old_prn in the remap table.
REQ-026 DONE SHALL last exactly one cycle with flush_done=1, then return to IDLE.
REQ-027 flush_valid outside IDLE SHALL be ignored.
REQ-028 A commit that would move head past target SHALL be treated as a protocol violation; behaviour in that case is undefined.
REQ-029 Walk latency SHALL be (tail - flush_ptr) + 1 cycles from flush acceptance to flush_done.

Reset
REQ-030 Asserting rst SHALL asynchronously set head=tail=0, state=IDLE, and force all valid outputs, flush_done and rename_stall to 0; a walk in progress is abandoned.
REQ-031 alloc_ready SHALL be 1 in the first cycle after rst deasserts.

Configuration
REQ-032 With RENREC_PERF_EN defined, the block SHALL add outputs perf_flushes and perf_walk_cycles (32 bits each, saturating), counting accepted flushes and cycles spent in WALK, cleared by rst.
REQ-033 Without RENREC_PERF_EN, these ports and counters SHALL be absent.

Structure
REQ-034 Package rename_pkg SHALL hold the undo_rec_t struct (arn, old_prn, new_prn), the state enum, and the ARN sentinel constants ARN_INVALID=62 and ARN_ZERO=63.
REQ-035 Storage SHALL be the sub-module ren_undo_log: multi-push, multi-pop and single-pop-from-tail circular buffer; the FSM stays in ren_recovery_ctrl.

Verification
REQ-036 Post-reset push of lanes {1,0,1}: arns {5,-,7} -> entries 0,1 hold arn 5 and arn 7, tail=2, log_tail=0 in the push cycle.
REQ-037 Push 3 records, then flush_ptr=0 -> restore arn sequence reversed over 3 cycles, walk_free_prn = new PRNs, flush_done in cycle 4, rename_stall high in cycles 1-4.
REQ-038 Two writes to arn 3 (old 3->40, then 40->41), flush to before both -> final restore_prn=3; PRNs 41 then 40 freed.
REQ-039 flush_ptr == tail -> no restore_valid; flush_done in the next cycle.
REQ-040 Fill to LOG_DEPTH-2 -> alloc_ready=0; commit_count=3 -> retire_free shows head old PRNs and alloc_ready=1 in the next cycle; pointers wrap correctly.
REQ-041 rst asserted mid-WALK -> outputs 0 immediately; IDLE with empty log after release.

Source files
------------

// File: rtl/rename_pkg.sv
// Shared types for the rename recovery slice.
//   undo_rec_t  : one undo-log record (overwritten mapping + newly allocated PRN)
//   ren_state_e : recovery controller state
//   ARN_INVALID / ARN_ZERO : architectural register sentinels
// Record fields are sized by REC_ARN_BITS / REC_PRN_BITS; instances of the
// controller must not configure wider register numbers than these.
package rename_pkg;

  localparam int REC_ARN_BITS = 6;
  localparam int REC_PRN_BITS = 6;

  localparam logic [REC_ARN_BITS-1:0] ARN_INVALID = 6'd62;
  localparam logic [REC_ARN_BITS-1:0] ARN_ZERO    = 6'd63;

  typedef struct packed {
    logic [REC_ARN_BITS-1:0] arn;
    logic [REC_PRN_BITS-1:0] old_prn;
    logic [REC_PRN_BITS-1:0] new_prn;
  } undo_rec_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WALK = 2'd1,
    DONE = 2'd2
  } ren_state_e;

endpackage

// File: rtl/ren_undo_log.sv
// Circular undo log: multi-push at tail, multi-pop at head, single pop from tail.
// Pointers carry an extra wrap bit so full and empty are distinguishable.
// Ports:
//   clk, rst       : clock, asynchronous active-high reset (pointers only)
//   push_valid     : per-lane write enables, already qualified by the caller;
//                    valid lanes are packed into consecutive entries from tail
//   push_rec       : per-lane records
//   pop_count      : records to drop from head this cycle (already clamped)
//   pop_tail       : step tail back by one entry
//   head, tail     : current pointers
//   head_old_prn   : old_prn of entries head+0 .. head+MAX_OPERANDS-1
//   tail_rec       : record at tail-1 (the youngest entry)
module ren_undo_log
  import rename_pkg::*;
#(
  parameter  int MAX_OPERANDS = 3,
  parameter  int LOG_DEPTH    = 32,
  localparam int PTR_BITS     = $clog2(LOG_DEPTH) + 1,
  localparam int CNT_BITS     = $clog2(MAX_OPERANDS + 1)
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [MAX_OPERANDS-1:0] push_valid,
  input  undo_rec_t               push_rec [MAX_OPERANDS],
  input  logic [CNT_BITS-1:0]     pop_count,
  input  logic                    pop_tail,
  output logic [PTR_BITS-1:0]     head,
  output logic [PTR_BITS-1:0]     tail,
  output logic [REC_PRN_BITS-1:0] head_old_prn [MAX_OPERANDS],
  output undo_rec_t               tail_rec
);

  localparam int IDX_BITS = PTR_BITS - 1;

  undo_rec_t           mem [LOG_DEPTH];
  logic [PTR_BITS-1:0] head_q;
  logic [PTR_BITS-1:0] tail_q;
  logic [PTR_BITS-1:0] wr_ptr [MAX_OPERANDS];
  logic [CNT_BITS-1:0] push_n;

  // Each valid lane lands at tail plus the number of valid lanes below it.
  always_comb begin
    push_n = '0;
    for (int unsigned i = 0; i < MAX_OPERANDS; i++) begin
      wr_ptr[i] = tail_q + PTR_BITS'(push_n);
      if (push_valid[i]) push_n = push_n + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    for (int unsigned i = 0; i < MAX_OPERANDS; i++) begin
      if (push_valid[i]) mem[wr_ptr[i][IDX_BITS-1:0]] <= push_rec[i];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      head_q <= '0;
      tail_q <= '0;
    end else begin
      head_q <= head_q + PTR_BITS'(pop_count);
      if (pop_tail) tail_q <= tail_q - PTR_BITS'(1);
      else          tail_q <= tail_q + PTR_BITS'(push_n);
    end
  end

  always_comb begin
    for (int unsigned i = 0; i < MAX_OPERANDS; i++) begin
      head_old_prn[i] = mem[IDX_BITS'(head_q + PTR_BITS'(i))].old_prn;
    end
  end

  assign tail_rec = mem[IDX_BITS'(tail_q - PTR_BITS'(1))];
  assign head     = head_q;
  assign tail     = tail_q;

endmodule

// File: rtl/ren_recovery_ctrl.sv
// Rename recovery controller: records every destination remap in an undo log,
// frees old PRNs when records retire, and on a flush walks the log backwards
// from tail to the flush point, restoring old mappings youngest-first and
// freeing the squashed new PRNs.
// Ports:
//   clk, rst                  : clock, asynchronous active-high reset
//   alloc_valid/arn/old/new   : per-lane remap records from the renamer
//   alloc_ready               : room for MAX_OPERANDS records and state IDLE
//   log_tail                  : tail pointer before this cycle's pushes
//   commit_count              : records retired from head this cycle
//   retire_free_valid/prn     : old PRNs of retired records
//   flush_valid, flush_ptr    : roll the log back to flush_ptr
//   restore_valid/arn/prn     : remap rewrite during the walk
//   walk_free_valid/prn       : squashed new PRN returned during the walk
//   rename_stall              : high whenever not IDLE
//   flush_done                : one-cycle pulse at the end of a flush
// Optional: define RENREC_PERF_EN to add saturating 32-bit counters
//   perf_flushes (accepted flushes) and perf_walk_cycles (cycles in WALK).
module ren_recovery_ctrl
  import rename_pkg::*;
#(
  parameter  int ARN_BITS     = 6,
  parameter  int PRN_BITS     = 6,
  parameter  int MAX_OPERANDS = 3,
  parameter  int LOG_DEPTH    = 32,
  localparam int PTR_BITS     = $clog2(LOG_DEPTH) + 1,
  localparam int CNT_BITS     = $clog2(MAX_OPERANDS + 1)
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [MAX_OPERANDS-1:0] alloc_valid,
  input  logic [ARN_BITS-1:0]     alloc_arn     [MAX_OPERANDS],
  input  logic [PRN_BITS-1:0]     alloc_old_prn [MAX_OPERANDS],
  input  logic [PRN_BITS-1:0]     alloc_new_prn [MAX_OPERANDS],
  output logic                    alloc_ready,
  output logic [PTR_BITS-1:0]     log_tail,
  input  logic [CNT_BITS-1:0]     commit_count,
  output logic [MAX_OPERANDS-1:0] retire_free_valid,
  output logic [PRN_BITS-1:0]     retire_free_prn [MAX_OPERANDS],
  input  logic                    flush_valid,
  input  logic [PTR_BITS-1:0]     flush_ptr,
  output logic                    restore_valid,
  output logic [ARN_BITS-1:0]     restore_arn,
  output logic [PRN_BITS-1:0]     restore_prn,
  output logic                    walk_free_valid,
  output logic [PRN_BITS-1:0]     walk_free_prn,
  output logic                    rename_stall,
  output logic                    flush_done
`ifdef RENREC_PERF_EN
  ,
  output logic [31:0]             perf_flushes,
  output logic [31:0]             perf_walk_cycles
`endif
);

  ren_state_e              state_q, state_d;
  logic [PTR_BITS-1:0]     target_q;
  logic [PTR_BITS-1:0]     head, tail, occupancy;
  logic                    flush_accept, pop_tail;
  logic [MAX_OPERANDS-1:0] push_valid;
  logic [CNT_BITS-1:0]     pop_count;
  undo_rec_t               push_rec [MAX_OPERANDS];
  undo_rec_t               tail_rec;
  logic [REC_PRN_BITS-1:0] head_old_prn [MAX_OPERANDS];

  assign occupancy    = tail - head;
  assign alloc_ready  = (state_q == IDLE) &&
                        (occupancy <= PTR_BITS'(LOG_DEPTH - MAX_OPERANDS));
  assign flush_accept = (state_q == IDLE) && flush_valid;
  // A flush in the same cycle wins over the renamer's pushes.
  assign push_valid   = (alloc_ready && !flush_valid) ? alloc_valid : '0;
  assign pop_count    = (PTR_BITS'(commit_count) > occupancy) ? CNT_BITS'(occupancy)
                                                              : commit_count;
  assign log_tail     = tail;
  assign rename_stall = (state_q != IDLE);

  always_comb begin
    for (int unsigned i = 0; i < MAX_OPERANDS; i++) begin
      push_rec[i] = '{arn:     REC_ARN_BITS'(alloc_arn[i]),
                      old_prn: REC_PRN_BITS'(alloc_old_prn[i]),
                      new_prn: REC_PRN_BITS'(alloc_new_prn[i])};
      retire_free_valid[i] = (CNT_BITS'(i) < pop_count);
      retire_free_prn[i]   = PRN_BITS'(head_old_prn[i]);
    end
  end

  ren_undo_log #(
    .MAX_OPERANDS (MAX_OPERANDS),
    .LOG_DEPTH    (LOG_DEPTH)
  ) u_log (
    .clk          (clk),
    .rst          (rst),
    .push_valid   (push_valid),
    .push_rec     (push_rec),
    .pop_count    (pop_count),
    .pop_tail     (pop_tail),
    .head         (head),
    .tail         (tail),
    .head_old_prn (head_old_prn),
    .tail_rec     (tail_rec)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      target_q <= '0;
    end else begin
      state_q <= state_d;
      if (flush_accept) target_q <= flush_ptr;
    end
  end

  // The walk shows the entry at tail-1 while stepping tail back onto it, so the
  // last restore happens in the cycle whose new tail equals the target.
  always_comb begin
    state_d         = state_q;
    pop_tail        = 1'b0;
    restore_valid   = 1'b0;
    walk_free_valid = 1'b0;
    flush_done      = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (flush_valid) state_d = (tail != flush_ptr) ? WALK : DONE;
      end
      WALK: begin
        pop_tail        = 1'b1;
        restore_valid   = 1'b1;
        walk_free_valid = 1'b1;
        if ((tail - PTR_BITS'(1)) == target_q) state_d = DONE;
      end
      DONE: begin
        flush_done = 1'b1;
        state_d    = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign restore_arn   = ARN_BITS'(tail_rec.arn);
  assign restore_prn   = PRN_BITS'(tail_rec.old_prn);
  assign walk_free_prn = PRN_BITS'(tail_rec.new_prn);

`ifdef RENREC_PERF_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      perf_flushes     <= '0;
      perf_walk_cycles <= '0;
    end else begin
      if (flush_accept && (perf_flushes != '1)) perf_flushes <= perf_flushes + 32'd1;
      if ((state_q == WALK) && (perf_walk_cycles != '1))
        perf_walk_cycles <= perf_walk_cycles + 32'd1;
    end
  end
`endif

endmodule
